cory_rdma3d: RTL

CORY_RDMA3D -- requirements
Module: cory_rdma3d

---
 rtl/cory_rdma3d.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cory_rdma3d.sv
// rtl/cory_rdma3d.sv - 3D strided read DMA (width x height x planes); CORY_RDMA3D_NEG_STRIDE_EN enables signed strides
module cory_rdma3d #(
  parameter int A = 32,
  parameter int L = 4,
  parameter int D = 64,
  parameter int S = 16,
  parameter int R = 11,
  parameter int P = 8,
  parameter int B = 16,
  parameter int O = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_cmd_v,
  output logic         o_cmd_r,
  input  logic [R-1:0] i_cmd_width,
  input  logic [R-1:0] i_cmd_height,
  input  logic [P-1:0] i_cmd_planes,
  input  logic [A-1:0] i_cmd_base,
  input  logic [S-1:0] i_cmd_lstride,
  input  logic [A-1:0] i_cmd_pstride,
  output logic         o_ar_v,
  output logic [A-1:0] o_ar_a,
  output logic [L-1:0] o_ar_l,
  input  logic         i_ar_r,
  input  logic         i_r_v,
  input  logic         i_r_l,
  input  logic [D-1:0] i_r_d,
  output logic         o_r_r,
  output logic         o_dout_v,
  output logic [D-1:0] o_dout_d,
  output logic         o_dout_eol,
  output logic         o_dout_eof,
  input  logic         i_dout_r,
  output logic         o_done
);
  localparam int CW = $clog2(O + 1);
  localparam logic [A-1:0]  BPB  = A'(D / 8);
  localparam logic [R-1:0]  BMAX = R'(B);
  localparam logic [CW-1:0] OMAX = CW'(O);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;

  logic [R-1:0]  width, height, ibeat, iline, dbeat, dline;
  logic [P-1:0]  planes, iplane, dplane;
  logic [A-1:0]  lstride, pstride, line_addr, plane_addr, lstride_in;
  logic          gen_done, done_q;
  logic [CW-1:0] outst, outst_nx;

`ifdef CORY_RDMA3D_NEG_STRIDE_EN
  assign lstride_in = A'($signed(i_cmd_lstride));
`else
  assign lstride_in = A'(i_cmd_lstride);
`endif

  logic cmd_hs, zero_cmd, ar_hs, r_hs, r_last_hs, load, line_end, d_eol, d_eof, last_hs;
  assign cmd_hs    = i_cmd_v & o_cmd_r;
  assign zero_cmd  = (i_cmd_width == '0) | (i_cmd_height == '0) | (i_cmd_planes == '0);
  assign ar_hs     = o_ar_v & i_ar_r;
  assign r_hs      = i_r_v & i_dout_r;
  assign r_last_hs = r_hs & i_r_l & (outst != '0);
  assign outst_nx  = outst + CW'(ar_hs) - CW'(r_last_hs);

  // Generator view: on accept, issue straight from the incoming command so AR appears one cycle later
  logic [R-1:0] g_width, g_height, g_beat, g_line, rem, blen;
  logic [P-1:0] g_planes, g_plane;
  logic [A-1:0] g_lstride, g_pstride, g_laddr, g_paddr;
  assign g_width   = cmd_hs ? i_cmd_width   : width;
  assign g_height  = cmd_hs ? i_cmd_height  : height;
  assign g_planes  = cmd_hs ? i_cmd_planes  : planes;
  assign g_lstride = cmd_hs ? lstride_in    : lstride;
  assign g_pstride = cmd_hs ? i_cmd_pstride : pstride;
  assign g_beat    = cmd_hs ? '0 : ibeat;
  assign g_line    = cmd_hs ? '0 : iline;
  assign g_plane   = cmd_hs ? '0 : iplane;
  assign g_laddr   = cmd_hs ? i_cmd_base : line_addr;
  assign g_paddr   = cmd_hs ? i_cmd_base : plane_addr;
  assign rem       = g_width - g_beat;
  assign blen      = (rem > BMAX) ? BMAX : rem;
  assign line_end  = (rem == blen);
  assign load      = ((cmd_hs & ~zero_cmd) | ((state == ISSUE) & ~gen_done))
                   & (~o_ar_v | i_ar_r) & (outst_nx < OMAX);

  assign d_eol   = (state != IDLE) & (dbeat == width - R'(1));
  assign d_eof   = d_eol & (dline == height - R'(1)) & (dplane == planes - P'(1));
  assign last_hs = (state == DRAIN) & r_hs & d_eof;

  assign o_dout_v   = i_r_v;
  assign o_dout_d   = i_r_d;
  assign o_r_r      = i_dout_r;
  assign o_dout_eol = d_eol;
  assign o_dout_eof = d_eof;
  assign o_done     = done_q | last_hs;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and command ready
  always_comb begin
    state_nx = state;
    o_cmd_r  = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_r = 1'b1;
        if (i_cmd_v && !zero_cmd) state_nx = ISSUE;
      end
      ISSUE: if (gen_done && ar_hs) state_nx = DRAIN;
      DRAIN: if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, burst generator and registered AR channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width <= '0; height <= '0; planes <= '0; lstride <= '0; pstride <= '0;
      ibeat <= '0; iline <= '0; iplane <= '0; line_addr <= '0; plane_addr <= '0;
      gen_done <= 1'b0; o_ar_v <= 1'b0; o_ar_a <= '0; o_ar_l <= '0;
    end else begin
      if (cmd_hs) begin
        width <= i_cmd_width; height <= i_cmd_height; planes <= i_cmd_planes;
        lstride <= lstride_in; pstride <= i_cmd_pstride;
        ibeat <= '0; iline <= '0; iplane <= '0;
        line_addr <= i_cmd_base; plane_addr <= i_cmd_base; gen_done <= 1'b0;
      end
      if (load) begin
        o_ar_v <= 1'b1;
        o_ar_a <= g_laddr + A'(g_beat) * BPB;
        o_ar_l <= L'(blen - R'(1));
        if (!line_end) begin
          ibeat <= g_beat + blen;
        end else begin
          ibeat <= '0;
          if (g_line != g_height - R'(1)) begin
            iline     <= g_line + R'(1);
            line_addr <= g_laddr + g_lstride;
          end else begin
            iline <= '0;
            if (g_plane == g_planes - P'(1)) begin
              gen_done <= 1'b1;
            end else begin
              iplane     <= g_plane + P'(1);
              plane_addr <= g_paddr + g_pstride;
              line_addr  <= g_paddr + g_pstride;
            end
          end
        end
      end else if (ar_hs) begin
        o_ar_v <= 1'b0;
      end
    end
  end

  // Outstanding bursts, data beat/line/plane position and empty-frame done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outst <= '0; dbeat <= '0; dline <= '0; dplane <= '0; done_q <= 1'b0;
    end else begin
      outst  <= outst_nx;
      done_q <= cmd_hs & zero_cmd;
      if (cmd_hs) begin
        dbeat <= '0; dline <= '0; dplane <= '0;
      end else if (r_hs && state != IDLE) begin
        if (!d_eol) begin
          dbeat <= dbeat + R'(1);
        end else begin
          dbeat <= '0;
          if (dline == height - R'(1)) begin
            dline  <= '0;
            dplane <= dplane + P'(1);
          end else begin
            dline <= dline + R'(1);
          end
        end
      end
    end
  end
endmodule
